// File: rtl/pulse_shrink.sv
// pulse_shrink: measures each synchronous high pulse and, at its falling edge, re-emits it shortened by trim_l + trim_r.
// Optional width reporting is compiled in with `define PULSE_SHRINK_WIDTH_REPORT_EN.
module pulse_shrink #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] trim_l,
    input  logic [CNT_W-1:0] trim_r,
    output logic             pulse_out,
    output logic [CNT_W-1:0] width_out,
    output logic             width_vld,
    output logic             drop,
    output logic             overrun
);

    typedef enum logic [0:0] {M_IDLE = 1'b0, M_CNT = 1'b1} m_state_t;
    typedef enum logic [0:0] {E_IDLE = 1'b0, E_RUN = 1'b1} e_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    m_state_t         m_state_reg, m_state_next;
    e_state_t         e_state_reg, e_state_next;
    logic             pulse_in_d_reg;
    logic [CNT_W-1:0] wcnt_reg, wcnt_next;
    logic [CNT_W-1:0] tl_reg, tl_next;
    logic [CNT_W-1:0] tr_reg, tr_next;
    logic [CNT_W-1:0] ecnt_reg, ecnt_next;
    logic             drop_reg, drop_next;
    logic             overrun_reg, overrun_next;

    logic             rise;
    logic             fall_evt;
    logic [CNT_W:0]   trim_sum;
    logic [CNT_W:0]   width_ext;
    logic [CNT_W:0]   emit_diff;
    logic             too_short;
    logic             emit_busy;
    logic             emit_start;

    // ---------------- evaluation at the falling edge ----------------
    // The trim sum carries one extra bit so huge trims can never wrap into a short emission.
    always_comb begin
        rise       = pulse_in & ~pulse_in_d_reg;
        fall_evt   = (m_state_reg == M_CNT) && !pulse_in;
        trim_sum   = {1'b0, tl_reg} + {1'b0, tr_reg};
        width_ext  = {1'b0, wcnt_reg};
        emit_diff  = width_ext - trim_sum;
        too_short  = (width_ext <= trim_sum);
        // An emission in its final cycle frees the emitter for a back-to-back start.
        emit_busy  = (e_state_reg == E_RUN) && (ecnt_reg != CNT_ONE);
        emit_start = fall_evt && !too_short && !emit_busy;
    end

    // ---------------- measure FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state_reg    <= M_IDLE;
            pulse_in_d_reg <= 1'b1;
            wcnt_reg       <= '0;
            tl_reg         <= '0;
            tr_reg         <= '0;
        end else begin
            m_state_reg    <= m_state_next;
            pulse_in_d_reg <= pulse_in;
            wcnt_reg       <= wcnt_next;
            tl_reg         <= tl_next;
            tr_reg         <= tr_next;
        end
    end

    always_comb begin
        m_state_next = m_state_reg;
        case (m_state_reg)
            M_IDLE:  if (rise)      m_state_next = M_CNT;
            M_CNT:   if (!pulse_in) m_state_next = M_IDLE;
            default:                m_state_next = M_IDLE;
        endcase
    end

    always_comb begin
        wcnt_next = wcnt_reg;
        tl_next   = tl_reg;
        tr_next   = tr_reg;
        if (m_state_reg == M_IDLE && rise) begin
            wcnt_next = CNT_ONE;
            tl_next   = trim_l;
            tr_next   = trim_r;
        end else if (m_state_reg == M_CNT && pulse_in && wcnt_reg != CNT_MAX) begin
            wcnt_next = wcnt_reg + CNT_ONE;
        end
    end

    // ---------------- emit FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_state_reg <= E_IDLE;
            ecnt_reg    <= '0;
            drop_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            e_state_reg <= e_state_next;
            ecnt_reg    <= ecnt_next;
            drop_reg    <= drop_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        e_state_next = e_state_reg;
        ecnt_next    = ecnt_reg;
        case (e_state_reg)
            E_IDLE: begin
                if (emit_start) begin
                    e_state_next = E_RUN;
                    ecnt_next    = emit_diff[CNT_W-1:0];
                end
            end
            E_RUN: begin
                if (emit_start) begin
                    ecnt_next = emit_diff[CNT_W-1:0];
                end else if (ecnt_reg == CNT_ONE) begin
                    e_state_next = E_IDLE;
                    ecnt_next    = '0;
                end else begin
                    ecnt_next = ecnt_reg - CNT_ONE;
                end
            end
            default: begin
                e_state_next = E_IDLE;
                ecnt_next    = '0;
            end
        endcase
    end

    always_comb begin
        pulse_out    = (e_state_reg == E_RUN);
        drop_next    = fall_evt && too_short;
        overrun_next = fall_evt && !too_short && emit_busy;
        drop         = drop_reg;
        overrun      = overrun_reg;
    end

    // ---------------- optional width report ----------------
`ifdef PULSE_SHRINK_WIDTH_REPORT_EN
    logic [CNT_W-1:0] width_reg;
    logic             width_vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_reg     <= '0;
            width_vld_reg <= 1'b0;
        end else begin
            width_vld_reg <= fall_evt;
            if (fall_evt) begin
                width_reg <= wcnt_reg;
            end
        end
    end

    assign width_out = width_reg;
    assign width_vld = width_vld_reg;
`else
    assign width_out = '0;
    assign width_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_shrink.sv
// Scoreboard bench for pulse_shrink: the driver predicts each pulse's outcome from its shape and trims,
// a negedge monitor pops those predictions and checks every output cycle by cycle.
module tb_pulse_shrink;

    localparam int CNT_W = 32;
    localparam int K_EMIT = 0;
    localparam int K_DROP = 1;
    localparam int K_OVR  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pulse_in = 1'b1;
    logic [CNT_W-1:0] trim_l = '0;
    logic [CNT_W-1:0] trim_r = '0;
    logic             pulse_out;
    logic [CNT_W-1:0] width_out;
    logic             width_vld;
    logic             drop;
    logic             overrun;

    pulse_shrink #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .trim_l    (trim_l),
        .trim_r    (trim_r),
        .pulse_out (pulse_out),
        .width_out (width_out),
        .width_vld (width_vld),
        .drop      (drop),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint edge_no;
        int     kind;
        longint w;
        longint len;
    } rec_t;

    rec_t   sb[$];
    longint cyc = 0;
    longint model_end = 0;   // driver's view: last edge after which pulse_out should be high
    longint exp_end = 0;     // monitor's view of the same
    longint exp_w = 0;
    int     errors = 0;
    int     checks = 0;
    int     n_emit = 0;
    int     n_drop = 0;
    int     n_ovr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the prediction whose falling edge was just sampled and checks all outputs.
    always @(negedge clk) begin
        logic e_drop, e_ovr, e_vld;
        rec_t r;
        e_drop = 1'b0;
        e_ovr  = 1'b0;
        e_vld  = 1'b0;
        if (!rst_n) begin
            sb.delete();
            exp_end = 0;
            exp_w   = 0;
        end else begin
            while (sb.size() > 0 && sb[0].edge_no == cyc) begin
                r = sb.pop_front();
                e_vld = 1'b1;
                exp_w = r.w;
                case (r.kind)
                    K_DROP:  begin e_drop = 1'b1; n_drop++; end
                    K_OVR:   begin e_ovr  = 1'b1; n_ovr++;  end
                    default: begin exp_end = r.edge_no + r.len - 1; n_emit++; end
                endcase
                $display("txn cycle=%0d kind=%s W=%0d len=%0d", cyc,
                         (r.kind == K_DROP) ? "drop" : (r.kind == K_OVR) ? "overrun" : "emit",
                         r.w, (r.kind == K_EMIT) ? r.len : 0);
            end
            if (sb.size() > 0 && sb[0].edge_no < cyc) begin
                chk("stale_prediction", 64'(sb[0].edge_no), 64'(cyc));
                void'(sb.pop_front());
            end
        end
        chk("pulse_out", 64'(pulse_out), 64'(rst_n && (cyc <= exp_end)));
        chk("drop", 64'(drop), 64'(e_drop));
        chk("overrun", 64'(overrun), 64'(e_ovr));
`ifdef PULSE_SHRINK_WIDTH_REPORT_EN
        chk("width_vld", 64'(width_vld), 64'(e_vld));
        chk("width_out", 64'(width_out), 64'(exp_w));
`else
        chk("width_vld", 64'(width_vld), 64'(0));
        chk("width_out", 64'(width_out), 64'(0));
`endif
    end

    task automatic step(input logic v);
        pulse_in = v;
        @(posedge clk);
        #1;
    endtask

    // Drive gap lows, a high of `high` cycles, then the low that ends it; predict the outcome.
    task automatic send_pulse(input int gap, input int high, input logic [CNT_W-1:0] tl,
                              input logic [CNT_W-1:0] tr, input bit chg);
        longint s;
        rec_t   r;
        for (int i = 0; i < gap; i++) step(1'b0);
        trim_l = tl;
        trim_r = tr;
        for (int i = 0; i < high; i++) begin
            step(1'b1);
            if (chg && i == 0) begin
                trim_l = '0;
                trim_r = CNT_W'($urandom_range(0, 9));
            end
        end
        step(1'b0);
        s = longint'(tl) + longint'(tr);
        r.edge_no = cyc;
        r.w       = high;
        r.len     = 0;
        if (longint'(high) <= s) begin
            r.kind = K_DROP;
        end else if (model_end >= cyc) begin
            r.kind = K_OVR;
        end else begin
            r.kind    = K_EMIT;
            r.len     = longint'(high) - s;
            model_end = cyc + r.len - 1;
        end
        sb.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pulse already high through reset: must be ignored entirely.
        pulse_in = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 5; i++) step(1'b0);

        send_pulse(3, 10, 32'd3, 32'd2, 1'b0);          // emit 5
        send_pulse(8, 5, 32'd3, 32'd2, 1'b0);           // drop
        send_pulse(8, 1, 32'd0, 32'd0, 1'b0);           // emit 1
        send_pulse(5, 20, 32'd0, 32'd0, 1'b0);          // emit 20
        send_pulse(0, 3, 32'd0, 32'd0, 1'b0);           // overrun
        send_pulse(25, 6, 32'd0, 32'd0, 1'b0);          // emit 6
        send_pulse(0, 5, 32'd0, 32'd0, 1'b0);           // back-to-back emit 5
        send_pulse(10, 8, 32'hFFFF_FFFF, 32'd1, 1'b0);  // drop, no wrap
        send_pulse(4, 10, 32'd3, 32'd0, 1'b1);          // trims changed mid-pulse: emit 7
        for (int i = 0; i < 12; i++) step(1'b0);

        // Reset in the third cycle of a 10-cycle emission.
        send_pulse(3, 10, 32'd0, 32'd0, 1'b0);
        step(1'b0);
        step(1'b0);
        chk("pulse_out_before_reset", 64'(pulse_out), 64'(1));
        rst_n = 1'b0;
        model_end = 0;
        #1;
        chk("pulse_out_async_clear", 64'(pulse_out), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) step(1'b0);

        for (int n = 0; n < 60; n++) begin
            send_pulse(int'($urandom_range(0, 6)), int'($urandom_range(1, 15)),
                       CNT_W'($urandom_range(0, 5)), CNT_W'($urandom_range(0, 5)),
                       bit'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 40; i++) step(1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        chk("emission_finished", 64'(cyc > exp_end), 64'(1));
        chk("saw_drop", 64'(n_drop > 0), 64'(1));
        chk("saw_overrun", 64'(n_ovr > 0), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_shrink.md
# pulse_shrink

Receive-side counterpart of the pulse extender: trims a stretched pulse back toward its original width. The block measures each incoming high pulse and, at its falling edge, emits a pulse shortened by `trim_l + trim_r` cycles. It also reports the measured width and discards pulses too short to survive trimming, which makes it a glitch filter too. It sits after synchronised flag/strobe inputs in the same clock domain as their consumers.

## Interface
- `CNT_W`, 32: width of the measure and emit counters and of the trim inputs.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pulse_in` in 1: extended pulse in; must already be synchronous to `clk`.
- `trim_l` in CNT_W: cycles to remove from the leading edge.
- `trim_r` in CNT_W: cycles to remove from the trailing edge.
- `pulse_out` out 1: shortened pulse.
- `width_out` out CNT_W: measured input width, in cycles, of the last completed pulse.
- `width_vld` out 1: one-cycle strobe qualifying `width_out`.
- `drop` out 1: one-cycle strobe; the pulse was too short and was discarded.
- `overrun` out 1: one-cycle strobe; a qualified pulse arrived while an emission was active and was discarded.

## Operation
- Reset values: all outputs 0. Internal `pulse_in_d` resets to 1, so a pulse already high at reset release has no rising edge and is ignored.
- **Measure FSM**
  - States: `M_IDLE` and `M_CNT`.
  - `M_IDLE` → `M_CNT` on rising edge (`pulse_in & ~pulse_in_d`). On entry: `wcnt <= 1`; latch `trim_l`/`trim_r` into `tl_q`/`tr_q`.
  - In `M_CNT`, each cycle `pulse_in` is high: `wcnt <= wcnt + 1`, saturating at all-ones.
  - Falling edge in `M_CNT` → `M_IDLE`; W = `wcnt`.
  - A falling edge while in `M_IDLE` is ignored.
- **Evaluate, at the falling edge**
  - S = `tl_q + tr_q`, computed CNT_W+1 bits wide with no wrap.
  - If W ≤ S: pulse `drop`.
  - Else if emitter busy: pulse `overrun`. The current emission continues unchanged.
  - Else: load `ecnt <= W − S` and start emitting.
- **Emit FSM**
  - States: `E_IDLE` and `E_RUN`.
  - `E_RUN` holds `pulse_out = 1` and decrements `ecnt`. It returns to `E_IDLE` after `ecnt` reaches 1, giving exactly W−S high cycles.
- Measurement runs independently of emission. A new pulse may be measured while the previous one is still being emitted.
- A saturated W is treated as a normal value. A pulse that never falls produces no output.
- Trims are sampled only at the rising edge. Changing `trim_l`/`trim_r` mid-pulse has no effect on that pulse.
- Asserting `rst_n` low mid-operation clears both FSMs and all counters immediately. Any partial emission is truncated and not resumed.

## Timing
- Let the falling edge of `pulse_in` be first sampled low at edge F.
- `pulse_out` rises in the cycle after edge F (registered output) and stays high for W−S cycles.
- `drop`/`overrun` each assert for exactly one cycle, in the cycle after F.
- Latency from the original pulse end to the shortened pulse start is 1 cycle. The output is therefore positioned after the input, not centred inside it.
- Back-to-back case: if emission ends at edge F, a new qualified falling edge also at F starts a new emission with no gap. `overrun` is not asserted.

## Configuration
- `PULSE_SHRINK_WIDTH_REPORT_EN` defined:
  - `width_out` is loaded with W at every falling edge processed in `M_CNT`, including dropped and overrun pulses.
  - `width_vld` strobes for one cycle in the cycle after F.
- Undefined:
  - `width_out` and `width_vld` are tied to 0, with no width register.
  - Pulse trimming, `drop` and `overrun` are unaffected.

## Test plan
- Trim 3/2, input high 10 cycles → `pulse_out` high 5 cycles starting 1 cycle after the falling edge; `width_out` = 10 with `width_vld` one cycle (macro defined).
- Trim 3/2, input high 5 cycles → no `pulse_out`; `drop` one cycle; `width_out` = 5.
- Trim 0/0, 1-cycle input → 1-cycle `pulse_out`, delayed 1 cycle after the input falls.
- Trim 0/0, input high 20 cycles, low 1 cycle, high 3 cycles → first output 20 cycles; `overrun` pulses for the second pulse; first output not shortened.
- `pulse_in` high during reset, released after 4 cycles high → no output and no strobes. Separately, `rst_n` asserted at cycle 3 of a 10-cycle emission → `pulse_out` 0 immediately and stays 0.
- Trim `trim_l` = 32'hFFFFFFFF, `trim_r` = 1, input high 8 cycles → `drop`, proving no wrap. Separately, `trim_l` changed from 3 to 0 mid-pulse → trim of 3 still applied.
